// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sequence player.
// Contents:
//   state_t  - sequencer states (IDLE, SETUP, SHIFT, HOLD, GAP)
//   CPOL_* / CPHA_* mode constants
//   cnt_w()  - width of a counter holding 0..n-1 (at least 1 bit)
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam bit CPOL_IDLE_LOW  = 1'b0;
  localparam bit CPOL_IDLE_HIGH = 1'b1;
  localparam bit CPHA_LEADING   = 1'b0;
  localparam bit CPHA_TRAILING  = 1'b1;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_seq_player_if.sv
// Bus bundle of the SPI sequence player.
//   start, abort : sequence control requests
//   miso         : serial data in
//   sclk, mosi, cs_n : SPI pins
//   busy, rx_valid, rx_word, rx_idx, seq_done : status / receive results
// master: the sequence player; slave: whoever drives control and observes results.
interface spi_seq_player_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_WORDS = 4
);
  import spi_pkg::*;

  localparam int unsigned IDX_W = cnt_w(NUM_WORDS);

  logic              start;
  logic              abort;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_word;
  logic [IDX_W-1:0]  rx_idx;
  logic              seq_done;

  modport master (
    input  start, abort, miso,
    output sclk, mosi, cs_n, busy, rx_valid, rx_word, rx_idx, seq_done
  );

  modport slave (
    output start, abort, miso,
    input  sclk, mosi, cs_n, busy, rx_valid, rx_word, rx_idx, seq_done
  );
endinterface

// File: rtl/spi_word_shifter.sv
// Single-word SPI shift engine: divider, SCLK generation, edge counting and
// the MOSI/MISO shift registers.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : abandon the current word, SCLK back to idle level
//   i_load     : latch i_tx_word and rearm (CPHA=0 also drives the MSB now)
//   i_run      : shifting phase active
//   i_tx_word  : word to transmit, MSB first
//   i_miso     : serial input
//   o_sclk, o_mosi : registered SPI pins
//   o_rx_word  : received word
//   o_done     : high in the cycle whose clock edge produces the last SCLK edge
module spi_word_shifter
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_tx_word,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic [DATA_W-1:0] o_rx_word,
  output logic              o_done
);
  localparam int unsigned DIV_W  = cnt_w(CLK_DIV);
  localparam int unsigned EDGE_W = cnt_w(2 * DATA_W);

  logic [DIV_W-1:0]  r_div;
  logic [EDGE_W-1:0] r_edges;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic              r_sclk;
  logic              r_mosi;

  logic w_edge;
  logic w_odd;
  logic w_last;
  logic w_sample;
  logic w_shift;

  // r_edges counts completed edges, so the edge being produced is r_edges+1.
  always_comb begin
    w_edge   = i_run && (r_div == DIV_W'(CLK_DIV - 1));
    w_odd    = ~r_edges[0];
    w_last   = (r_edges == EDGE_W'(2 * DATA_W - 1));
    w_sample = 1'b0;
    w_shift  = 1'b0;
    if (CPHA == CPHA_TRAILING) begin
      w_sample = w_edge && !w_odd;
      w_shift  = w_edge && w_odd;
    end else begin
      // MSB already out at load; the final even edge must not shift past the LSB
      w_sample = w_edge && w_odd;
      w_shift  = w_edge && !w_odd && !w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_edges <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_sclk  <= CPOL;
      r_mosi  <= 1'b0;
    end else if (i_clear) begin
      r_div   <= '0;
      r_edges <= '0;
      r_sclk  <= CPOL;
    end else if (i_load) begin
      r_div   <= '0;
      r_edges <= '0;
      r_sclk  <= CPOL;
      if (CPHA == CPHA_TRAILING) begin
        r_tx <= i_tx_word;
      end else begin
        r_mosi <= i_tx_word[DATA_W-1];
        r_tx   <= {i_tx_word[DATA_W-2:0], 1'b0};
      end
    end else if (i_run) begin
      if (w_edge) begin
        r_div   <= '0;
        r_edges <= r_edges + EDGE_W'(1);
        r_sclk  <= ~r_sclk;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      if (w_shift) begin
        r_mosi <= r_tx[DATA_W-1];
        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
      end
      if (w_sample) begin
        r_rx <= {r_rx[DATA_W-2:0], i_miso};
      end
    end
  end

  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_rx_word = r_rx;
  assign o_done    = w_edge && w_last;

endmodule

// File: rtl/spi_seq_player.sv
// SPI sequence master: plays NUM_WORDS words from the SEQ table over SPI in
// any CPOL/CPHA mode, capturing MISO full-duplex, one-shot or looping.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : spi_seq_player_if.master (start/abort/miso in; SPI pins, busy,
//          rx_valid/rx_word/rx_idx and seq_done out, all registered)
module spi_seq_player
  import spi_pkg::*;
#(
  parameter int unsigned                    DATA_W    = 8,
  parameter int unsigned                    NUM_WORDS = 4,
  parameter logic [DATA_W*NUM_WORDS-1:0]    SEQ       = 32'hA55A3CC3,
  parameter int unsigned                    CLK_DIV   = 2,
  parameter bit                             CPOL      = 1'b0,
  parameter bit                             CPHA      = 1'b0,
  parameter int unsigned                    GAP       = 2,
  parameter bit                             LOOP      = 1'b0
) (
  input logic                clk,
  input logic                rst,
  spi_seq_player_if.master   bus
);
  localparam int unsigned IDX_W   = cnt_w(NUM_WORDS);
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int unsigned CNT_W   = cnt_w(CNT_MAX);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_cs_n;
  logic              r_busy;
  logic              r_rx_valid;
  logic [DATA_W-1:0] r_rx_word;
  logic [IDX_W-1:0]  r_rx_idx;
  logic              r_seq_done;

  logic              w_div_end;
  logic              w_gap_end;
  logic              w_last_word;
  logic              w_load;
  logic              w_run;
  logic              w_done;
  logic [DATA_W-1:0] w_tx_word;
  logic [DATA_W-1:0] w_rx_word;
  logic              w_sclk;
  logic              w_mosi;

  always_comb begin
    w_div_end   = (r_cnt == CNT_W'(CLK_DIV - 1));
    w_gap_end   = (r_cnt == CNT_W'(GAP - 1));
    w_last_word = (r_idx == IDX_W'(NUM_WORDS - 1));
    // load coincides with every entry into SETUP
    w_load      = !bus.abort &&
                  (((r_state == ST_IDLE) && bus.start) ||
                   ((r_state == ST_GAP) && w_gap_end));
    w_run       = (r_state == ST_SHIFT);
    w_tx_word   = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (r_idx == IDX_W'(k)) w_tx_word = SEQ[DATA_W*k +: DATA_W];
    end
  end

  spi_word_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL),
    .CPHA    (CPHA)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (bus.abort),
    .i_load    (w_load),
    .i_run     (w_run),
    .i_tx_word (w_tx_word),
    .i_miso    (bus.miso),
    .o_sclk    (w_sclk),
    .o_mosi    (w_mosi),
    .o_rx_word (w_rx_word),
    .o_done    (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_word  <= '0;
      r_rx_idx   <= '0;
      r_seq_done <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_seq_done <= 1'b0;
      if (bus.abort) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_cs_n  <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              r_state <= ST_SETUP;
              r_cnt   <= '0;
              r_cs_n  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          ST_SETUP: begin
            if (w_div_end) begin
              r_state <= ST_SHIFT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_SHIFT: begin
            if (w_done) begin
              r_state <= ST_HOLD;
              r_cnt   <= '0;
            end
          end
          ST_HOLD: begin
            if (w_div_end) begin
              r_rx_valid <= 1'b1;
              r_rx_word  <= w_rx_word;
              r_rx_idx   <= r_idx;
              r_seq_done <= w_last_word;
              r_cs_n     <= 1'b1;
              r_cnt      <= '0;
              // index advances here so the GAP->SETUP load already sees the next word
              if (w_last_word) begin
                r_idx <= '0;
                if (LOOP) begin
                  r_state <= ST_GAP;
                end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_state <= ST_GAP;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (w_gap_end) begin
              r_state <= ST_SETUP;
              r_cnt   <= '0;
              r_cs_n  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sclk     = w_sclk;
  assign bus.mosi     = w_mosi;
  assign bus.cs_n     = r_cs_n;
  assign bus.busy     = r_busy;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_word  = r_rx_word;
  assign bus.rx_idx   = r_rx_idx;
  assign bus.seq_done = r_seq_done;

endmodule

// File: tb/tb_spi_seq_player.sv
// Directed bench for spi_seq_player: three instances (defaults with loopback,
// mode 3 with MISO high, looping 16-bit two-word table) sharing clk/rst.
module tb_spi_seq_player;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] word;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;

  logic [7:0] w_tab [4];

  spi_seq_player_if #(.DATA_W(8),  .NUM_WORDS(4)) b0 ();
  spi_seq_player_if #(.DATA_W(8),  .NUM_WORDS(4)) b1 ();
  spi_seq_player_if #(.DATA_W(16), .NUM_WORDS(2)) b2 ();

  assign b0.miso = b0.mosi;
  assign b1.miso = 1'b1;
  assign b2.miso = b2.mosi;

  spi_seq_player #(
    .DATA_W(8), .NUM_WORDS(4), .SEQ(32'hA55A3CC3), .CLK_DIV(2),
    .CPOL(1'b0), .CPHA(1'b0), .GAP(2), .LOOP(1'b0)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  spi_seq_player #(
    .DATA_W(8), .NUM_WORDS(4), .SEQ(32'hA55A3CC3), .CLK_DIV(2),
    .CPOL(1'b1), .CPHA(1'b1), .GAP(2), .LOOP(1'b0)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  spi_seq_player #(
    .DATA_W(16), .NUM_WORDS(2), .SEQ(32'h1234BEEF), .CLK_DIV(2),
    .CPOL(1'b0), .CPHA(1'b0), .GAP(2), .LOOP(1'b1)
  ) u2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard pops on every received word
  always @(negedge clk) begin
    if (b0.rx_valid === 1'b1) begin
      if (q0.size() == 0) chk("A unexpected rx_valid", b0.rx_valid, 1'b0);
      else begin
        e0 = q0.pop_front();
        chk("A rx_word", b0.rx_word, e0.word);
        chk("A rx_idx", b0.rx_idx, e0.idx);
      end
    end
  end

  always @(negedge clk) begin
    if (b1.rx_valid === 1'b1) begin
      if (q1.size() == 0) chk("B unexpected rx_valid", b1.rx_valid, 1'b0);
      else begin
        e1 = q1.pop_front();
        chk("B rx_word", b1.rx_word, e1.word);
        chk("B rx_idx", b1.rx_idx, e1.idx);
      end
    end
  end

  always @(negedge clk) begin
    if (b2.rx_valid === 1'b1) begin
      if (q2.size() == 0) chk("C unexpected rx_valid", b2.rx_valid, 1'b0);
      else begin
        e2 = q2.pop_front();
        chk("C rx_word", b2.rx_word, e2.word);
        chk("C rx_idx", b2.rx_idx, e2.idx);
        chk("C seq_done with rx_valid", b2.seq_done, e2.idx == 8'd1);
      end
    end
  end

  task automatic chk_reset0(input string tag);
    chk({tag, " sclk"},     b0.sclk,     1'b0);
    chk({tag, " cs_n"},     b0.cs_n,     1'b1);
    chk({tag, " mosi"},     b0.mosi,     1'b0);
    chk({tag, " busy"},     b0.busy,     1'b0);
    chk({tag, " rx_valid"}, b0.rx_valid, 1'b0);
    chk({tag, " rx_word"},  b0.rx_word,  8'h00);
    chk({tag, " rx_idx"},   b0.rx_idx,   2'd0);
    chk({tag, " seq_done"}, b0.seq_done, 1'b0);
  endtask

  // start launched right after "edge 0"; loop index n = edges since then
  task automatic run_default(input bit extra_start);
    logic exp_cs, exp_rv, pcs, psclk;
    int   edges;
    for (int k = 0; k < 4; k++) q0.push_back('{idx: 8'(k), word: {24'h0, w_tab[k]}});
    pcs   = 1'b1;
    psclk = 1'b0;
    edges = 0;
    b0.start = 1'b1;
    for (int n = 1; n <= 160; n++) begin
      tick();
      if (n == 1) b0.start = 1'b0;
      if (extra_start && n == 49) b0.start = 1'b1;
      if (extra_start && n == 50) b0.start = 1'b0;
      exp_cs = 1'b1;
      for (int k = 0; k < 4; k++) if (n >= 1 + 38*k && n <= 36 + 38*k) exp_cs = 1'b0;
      exp_rv = (n >= 37) && (n <= 151) && ((n - 37) % 38 == 0);
      chk("A cs_n", b0.cs_n, exp_cs);
      chk("A rx_valid timing", b0.rx_valid, exp_rv);
      chk("A busy", b0.busy, n <= 150);
      chk("A seq_done", b0.seq_done, n == 151);
      if (b0.cs_n) chk("A sclk idle", b0.sclk, 1'b0);
      if (b0.sclk !== psclk && b0.cs_n === 1'b0) edges++;
      if (b0.cs_n === 1'b1 && pcs === 1'b0) begin
        chk("A sclk edges per word", edges, 16);
        edges = 0;
      end
      pcs   = b0.cs_n;
      psclk = b0.sclk;
    end
    chk("A scoreboard drained", q0.size(), 0);
  endtask

  initial begin
    logic       psclk, pmosi, pcs;
    logic [7:0] cap;
    int         word;
    bit         gap_checked;

    w_tab[0] = 8'hC3; w_tab[1] = 8'h3C; w_tab[2] = 8'h5A; w_tab[3] = 8'hA5;
    rst = 1'b1;
    b0.start = 1'b0; b0.abort = 1'b0;
    b1.start = 1'b0; b1.abort = 1'b0;
    b2.start = 1'b0; b2.abort = 1'b0;
    repeat (3) tick();
    chk_reset0("reset");
    chk("reset B sclk idles high", b1.sclk, 1'b1);
    chk("reset C busy", b2.busy, 1'b0);
    rst = 1'b0;
    tick();

    // plain one-shot sequence, then with a start pulse while busy
    run_default(1'b0);
    repeat (3) tick();
    run_default(1'b1);
    repeat (3) tick();

    // abort mid word 0
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    repeat (19) tick();
    chk("abort pre cs_n low", b0.cs_n, 1'b0);
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0;
    chk("abort busy", b0.busy, 1'b0);
    chk("abort cs_n", b0.cs_n, 1'b1);
    chk("abort sclk", b0.sclk, 1'b0);
    chk("abort rx_word kept", b0.rx_word, 8'hA5);
    for (int n = 0; n < 60; n++) begin
      tick();
      chk("abort stays idle", b0.busy, 1'b0);
    end

    // start and abort together in IDLE
    b0.start = 1'b1;
    b0.abort = 1'b1;
    tick();
    b0.start = 1'b0;
    b0.abort = 1'b0;
    chk("start+abort busy", b0.busy, 1'b0);
    chk("start+abort cs_n", b0.cs_n, 1'b1);
    tick();
    chk("start+abort still idle", b0.busy, 1'b0);
    tick();
    run_default(1'b0);
    repeat (3) tick();

    // reset mid-SHIFT
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    repeat (8) tick();
    chk("pre-rst busy", b0.busy, 1'b1);
    rst = 1'b1;
    tick();
    chk_reset0("mid rst");
    rst = 1'b0;
    repeat (2) tick();
    run_default(1'b0);

    // mode 3, MISO held high
    for (int k = 0; k < 4; k++) q1.push_back('{idx: 8'(k), word: 32'hFF});
    psclk = b1.sclk; pmosi = b1.mosi; pcs = b1.cs_n;
    cap = '0; word = 0;
    b1.start = 1'b1;
    for (int n = 1; n <= 160; n++) begin
      tick();
      if (n == 1) b1.start = 1'b0;
      chk("B seq_done", b1.seq_done, n == 151);
      chk("B busy", b1.busy, n <= 150);
      if (b1.cs_n === 1'b1) chk("B sclk idle high", b1.sclk, 1'b1);
      if (b1.mosi !== pmosi) chk("B mosi moves on falling edge", {psclk, b1.sclk}, 2'b10);
      if (psclk === 1'b0 && b1.sclk === 1'b1 && b1.cs_n === 1'b0) cap = {cap[6:0], b1.mosi};
      if (b1.cs_n === 1'b1 && pcs === 1'b0) begin
        if (word < 4) chk("B mosi word", cap, w_tab[word]);
        word++;
      end
      psclk = b1.sclk; pmosi = b1.mosi; pcs = b1.cs_n;
    end
    chk("B words seen", word, 4);
    chk("B scoreboard drained", q1.size(), 0);

    // looping two-word table, 16-bit words
    for (int k = 0; k < 5; k++)
      q2.push_back('{idx: 8'(k % 2), word: (k % 2 == 1) ? 32'h1234 : 32'hBEEF});
    gap_checked = 1'b0;
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    for (int n = 0; n < 600 && q2.size() != 0; n++) begin
      tick();
      if (b2.seq_done === 1'b1 && !gap_checked) begin
        gap_checked = 1'b1;
        chk("C cs_n high at seq_done", b2.cs_n, 1'b1);
        tick();
        chk("C gap cs_n high", b2.cs_n, 1'b1);
        tick();
        chk("C next pass cs_n low", b2.cs_n, 1'b0);
      end
    end
    chk("C scoreboard drained", q2.size(), 0);
    chk("C seq_done observed", gap_checked, 1'b1);
    repeat (10) tick();
    chk("C still busy before abort", b2.busy, 1'b1);
    b2.abort = 1'b1;
    tick();
    b2.abort = 1'b0;
    chk("C abort busy", b2.busy, 1'b0);
    chk("C abort cs_n", b2.cs_n, 1'b1);
    chk("C abort sclk", b2.sclk, 1'b0);
    for (int n = 0; n < 200; n++) begin
      tick();
      chk("C stays idle after abort", b2.busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
